// File: rtl/shift_pkg.sv
// Shared definitions for the RV64 shift execution unit: opcode encodings,
// opcode decode helpers and a bit-reversal helper for the single-shifter datapath.
package shift_pkg;

    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        SHIFT_SLL  = 3'b000,
        SHIFT_SRL  = 3'b001,
        SHIFT_SRA  = 3'b010,
        SHIFT_SLLW = 3'b100,
        SHIFT_SRLW = 3'b101,
        SHIFT_SRAW = 3'b110
    } shift_op_e;

    function automatic logic is_word(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_right(input logic [2:0] op);
        return (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op[1:0] == 2'b10);
    endfunction

    function automatic logic is_illegal(input logic [2:0] op);
        return (op[1:0] == 2'b11);
    endfunction

    function automatic logic [XLEN-1:0] reverse_bits(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_fill_mask.sv
// Arithmetic-fill mask: ones in the bit positions vacated by a right shift,
// measured from bit 63 (doubleword) or bit 31 (word, upper half left clear).
module shift_fill_mask
    import shift_pkg::*;
(
    input  logic [5:0]      shamt,
    input  logic            word,
    output logic [XLEN-1:0] fill_mask
);

    logic [31:0]     mask32_s;
    logic [XLEN-1:0] mask64_s;

    // Word masks only matter up to bit 31; the caller sign-extends from there.
    always_comb begin
        mask32_s  = ~(32'hFFFF_FFFF >> shamt[4:0]);
        mask64_s  = ~({XLEN{1'b1}} >> shamt);
        fill_mask = {XLEN{1'b0}};
        if (word) begin
            fill_mask = {32'h0000_0000, mask32_s};
        end else begin
            fill_mask = mask64_s;
        end
    end

endmodule

// File: rtl/shift_exec_unit.sv
// Two-stage pipelined RV64 shift unit: S1 latches prepared operands, S2 performs
// the shift/fill and holds the output register presented to writeback.
module shift_exec_unit #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_src,
    input  logic [5:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    import shift_pkg::*;

    logic             s1_valid_r;
    logic [2:0]       s1_op_r;
    logic [XLEN-1:0]  s1_src_r;
    logic [5:0]       s1_shamt_r;
    logic             s1_sign_r;
    logic [TAG_W-1:0] s1_tag_r;

    logic             s2_valid_r;
    logic [XLEN-1:0]  s2_result_r;
    logic [TAG_W-1:0] s2_tag_r;
    logic             s2_illegal_r;

    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             accept_s;

    logic [XLEN-1:0]  fill_mask_s;
    logic [XLEN-1:0]  shl_in_s;
    logic [XLEN-1:0]  shl_out_s;
    logic [XLEN-1:0]  raw_s;
    logic [XLEN-1:0]  filled_s;
    logic [XLEN-1:0]  result_s;

    // Handshake control; in_ready follows out_ready combinationally (no skid buffer).
    always_comb begin
        s2_adv_s   = !s2_valid_r || out_ready;
        s1_adv_s   = s2_adv_s;
        in_ready_s = !flush && (!s1_valid_r || s1_adv_s);
        accept_s   = in_valid && in_ready_s;
    end

    assign in_ready = in_ready_s;

    // S1 operand prep: W ops zero-extend the low word and drop shamt bit 5.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            s1_op_r    <= in_op;
            s1_tag_r   <= in_tag;
            if (is_word(in_op)) begin
                s1_src_r   <= {32'h0000_0000, in_src[31:0]};
                s1_shamt_r <= {1'b0, in_shamt[4:0]};
                s1_sign_r  <= in_src[31];
            end else begin
                s1_src_r   <= in_src;
                s1_shamt_r <= in_shamt;
                s1_sign_r  <= in_src[XLEN-1];
            end
        end
    end

    shift_fill_mask u_fill_mask (
        .shamt     (s1_shamt_r),
        .word      (is_word(s1_op_r)),
        .fill_mask (fill_mask_s)
    );

    // S2 datapath: right shifts reverse the operand around the one left shifter.
    always_comb begin
        shl_in_s  = is_right(s1_op_r) ? reverse_bits(s1_src_r) : s1_src_r;
        shl_out_s = shl_in_s << s1_shamt_r;
        raw_s     = is_right(s1_op_r) ? reverse_bits(shl_out_s) : shl_out_s;
        filled_s  = raw_s;
        if (is_arith(s1_op_r) && s1_sign_r) begin
            filled_s = raw_s | fill_mask_s;
        end else begin
            filled_s = raw_s;
        end
        result_s = filled_s;
        if (is_illegal(s1_op_r)) begin
            result_s = {XLEN{1'b0}};
        end else if (is_word(s1_op_r)) begin
            result_s = {{32{filled_s[31]}}, filled_s[31:0]};
        end else begin
            result_s = filled_s;
        end
    end

    // Valid bits and output register; flush outranks every handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r   <= 1'b0;
            s2_valid_r   <= 1'b0;
            s2_result_r  <= {XLEN{1'b0}};
            s2_tag_r     <= {TAG_W{1'b0}};
            s2_illegal_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                s1_valid_r <= 1'b1;
            end else if (s1_adv_s) begin
                s1_valid_r <= 1'b0;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_result_r  <= result_s;
                    s2_tag_r     <= s1_tag_r;
                    s2_illegal_r <= is_illegal(s1_op_r);
                end
            end
        end
    end

    assign out_valid   = s2_valid_r;
    assign out_result  = s2_result_r;
    assign out_tag     = s2_tag_r;
    assign out_illegal = s2_illegal_r;

endmodule
